multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Control FSM for the multi-cycle RV32I datapath: the issuing side of the ALU interface.
//  Decodes the instruction register and sequences fetch/decode/execute/memory/writeback.
//  Each cycle it drives alu_op and the operand selects, and consumes the ALU zero/lsb flags.
//  Shares one unified memory port with a req/ready handshake.
// PARAMETERS
//  none (encodings fixed in shared package)
// PORTS
//  clk         in   1  clock; all state changes on rising edge
//  rst         in   1  synchronous, active-high reset
//  opcode      in   7  instr[6:0] from instruction register
//  funct3      in   3  instr[14:12]
//  funct7b5    in   1  instr[30]
//  alu_zero    in   1  ALU out == 0, current cycle
//  alu_lsb     in   1  ALU out[0], current cycle
//  mem_ready   in   1  memory completes the held request this cycle
//  mem_req     out  1  memory request; held until mem_ready
//  mem_we      out  1  write strobe, valid with mem_req
//  addr_src    out  1  0=PC, 1=ALUOut register
//  ir_write    out  1  load instruction register (and oldPC)
//  pc_write    out  1  load PC
//  pc_src      out  1  0=ALU result, 1=ALUOut register
//  alu_src_a   out  2  0=PC, 1=oldPC, 2=rs1
//  alu_src_b   out  2  0=rs2, 1=imm, 2=const 4
//  alu_op      out  alu_ops_t  operation for ALU
//  result_src  out  2  0=ALUOut, 1=mem read data, 2=ALU result
//  reg_write   out  1  write rd
//  instr_done  out  1  1-cycle pulse in final state of each instruction
//  illegal     out  1  high while in ILLEGAL state
// BEHAVIOUR
//  - Moore outputs decoded from state (+ mem_ready, funct3, flags where noted).
//  - Defaults: all 1-bit outs 0, selects 0, alu_op=ALU_ADD.
//  - rst high: next state FETCH, outputs forced to defaults (mem_req=0).
//    Reset mid-request aborts the request; the memory must tolerate it.
//  - FETCH: mem_req=1, addr_src=0; stay while !mem_ready.
//    On mem_ready: ir_write=1, pc_write=1, src_a=PC, src_b=4, ADD, pc_src=0 -> DECODE.
//  - DECODE: src_a=oldPC, src_b=imm, ADD (branch/JAL/AUIPC target into ALUOut). Next:
//    LOAD 0000011/STORE 0100011->MEMADR; R 0110011->EXECR; OP-IMM 0010011->EXECI;
//    BRANCH 1100011->BRANCH; JAL 1101111->JAL; JALR 1100111->JALRADR;
//    LUI 0110111->LUI; AUIPC 0010111->ALUWB; other->ILLEGAL.
//  - MEMADR: src_a=rs1, src_b=imm, ADD -> MEMREAD if opcode LOAD, else MEMWRITE.
//  - MEMREAD: mem_req=1, addr_src=1; wait for ready -> MEMWB.
//  - MEMWB: result_src=1, reg_write=1, instr_done -> FETCH.
//  - MEMWRITE: mem_req=1, mem_we=1, addr_src=1; on ready instr_done -> FETCH.
//  - EXECR/EXECI: src_a=rs1, src_b=rs2 (R) / imm (I), alu_op per decode below -> ALUWB.
//  - ALUWB: result_src=0, reg_write=1, instr_done -> FETCH.
//  - BRANCH: src_a=rs1, src_b=rs2; pc_src=1.
//    f3 000/001: SUB, take=zero/!zero. 100/101: SLT, take=lsb/!lsb.
//    110/111: SLTU, take=lsb/!lsb. pc_write=take, instr_done -> FETCH.
//    f3 010/011 -> ILLEGAL (no pc_write).
//  - JALRADR: src_a=rs1, src_b=imm, ADD -> JAL.
//  - JAL: pc_write=1, pc_src=1; src_a=oldPC, src_b=4, ADD (link into ALUOut) -> ALUWB.
//  - LUI: src_b=imm, ALU_LUI -> ALUWB.
//  - ILLEGAL: illegal=1, no writes/requests; absorbing until rst.
//  - ALU decode (f3): 000 ADD (SUB if R & f7b5), 001 SLL, 010 SLT, 011 SLTU,
//    100 XOR, 101 SRL/SRA by f7b5 (R and I), 110 OR, 111 AND. OP-IMM 000 never SUB.
//  - Latency at zero-wait memory: R/I/LUI/AUIPC 4 (AUIPC 3), load 5, store 4,
//    branch 3, JAL 4, JALR 5. Each mem wait cycle adds 1.
//  - mem_req, mem_we and addr_src are stable from first assertion until mem_ready.
// STRUCTURE
//  - Shared package (header.sv): alu_ops_t (existing), opcode localparams,
//    mc_state_t enum, select encodings for src_a/src_b/result_src.
//  - Sub-module alu_decoder: combinational {opcode,funct3,funct7b5} -> alu_ops_t.
//  - FSM: one state register plus a next-state/output always_comb.
// TESTING
//  - add x3,x1,x2 (0x002081B3), ready always 1 -> 4 cycles; EXECR alu_op=ADD;
//    reg_write only in ALUWB; one instr_done.
//  - sub (f7b5=1) -> SUB; srai (f3=101, f7b5=1) -> SRA; addi f7b5=1 -> ADD.
//  - lw, mem_ready low 3 cycles in MEMREAD -> mem_req/addr_src=1 stable 4 cycles,
//    then MEMWB result_src=1.
//  - beq with alu_zero=1 -> pc_write=1, pc_src=1; alu_zero=0 -> pc_write=0.
//    bltu, lsb=1 -> SLTU, taken.
//  - jalr -> JALRADR(ADD rs1+imm), JAL(pc_write, pc_src=1), ALUWB(reg_write); 5 cycles.
//  - opcode 0000000 -> ILLEGAL, illegal=1 for 10 cycles, no mem_req;
//    rst pulse -> FETCH; rst during MEMWRITE wait -> mem_req=0 next cycle.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: ALU operations,
// opcode values, controller states and datapath select encodings.
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_LUI  = 4'd10
    } alu_ops_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JALRADR  = 4'd10,
        S_JAL      = 4'd11,
        S_LUI      = 4'd12,
        S_ILLEGAL  = 4'd13
    } mc_state_t;

    localparam logic [1:0] SRC_A_PC    = 2'd0;
    localparam logic [1:0] SRC_A_OLDPC = 2'd1;
    localparam logic [1:0] SRC_A_RS1   = 2'd2;

    localparam logic [1:0] SRC_B_RS2   = 2'd0;
    localparam logic [1:0] SRC_B_IMM   = 2'd1;
    localparam logic [1:0] SRC_B_FOUR  = 2'd2;

    localparam logic [1:0] RES_ALUOUT    = 2'd0;
    localparam logic [1:0] RES_MEMDATA   = 2'd1;
    localparam logic [1:0] RES_ALURESULT = 2'd2;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU operation decode for register and immediate arithmetic instructions.
// SUB is only possible for register-register ops; shifts pick SRA by funct7b5.
module multicycle_controller_alu_decoder
    import multicycle_controller_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output alu_ops_t   alu_op
);

    logic is_r;

    assign is_r = (opcode == OP_R);

    // funct3 selects the operation; funct7b5 refines ADD/SUB and SRL/SRA
    always_comb begin
        alu_op = ALU_ADD;
        case (funct3)
            3'b000:  alu_op = (is_r && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_op = ALU_SLL;
            3'b010:  alu_op = ALU_SLT;
            3'b011:  alu_op = ALU_SLTU;
            3'b100:  alu_op = ALU_XOR;
            3'b101:  alu_op = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            3'b111:  alu_op = ALU_AND;
            default: alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multi-cycle RV32I datapath. Sequences fetch, decode,
// execute, memory and writeback, driving ALU operand selects and operation.
//
// Memory handshake: mem_req is raised together with mem_we and addr_src and
// all three are held unchanged until the cycle in which mem_ready is high;
// that cycle completes the transfer. Reset drops mem_req immediately.
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       alu_zero,
    input  logic       alu_lsb,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output alu_ops_t   alu_op,
    output logic [1:0] result_src,
    output logic       reg_write,
    output logic       instr_done,
    output logic       illegal
);

    mc_state_t state;
    mc_state_t next_state;
    alu_ops_t  dec_op;
    logic      take;

    multicycle_controller_alu_decoder u_alu_decoder (
        .opcode   (opcode),
        .funct3   (funct3),
        .funct7b5 (funct7b5),
        .alu_op   (dec_op)
    );

    // State register; reset returns to FETCH
    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH;
        else     state <= next_state;
    end

    // Next-state and Moore outputs; everything at defaults while in reset
    always_comb begin
        next_state = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_src   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_RS2;
        alu_op     = ALU_ADD;
        result_src = RES_ALUOUT;
        reg_write  = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        take       = 1'b0;
        if (rst) begin
            next_state = S_FETCH;
        end else begin
            case (state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write   = 1'b1;
                        pc_write   = 1'b1;
                        alu_src_a  = SRC_A_PC;
                        alu_src_b  = SRC_B_FOUR;
                        next_state = S_DECODE;
                    end
                end
                S_DECODE: begin
                    // oldPC + imm lands in ALUOut for branch/JAL/AUIPC
                    alu_src_a = SRC_A_OLDPC;
                    alu_src_b = SRC_B_IMM;
                    case (opcode)
                        OP_LOAD, OP_STORE: next_state = S_MEMADR;
                        OP_R:              next_state = S_EXECR;
                        OP_IMM:            next_state = S_EXECI;
                        OP_BRANCH:         next_state = S_BRANCH;
                        OP_JAL:            next_state = S_JAL;
                        OP_JALR:           next_state = S_JALRADR;
                        OP_LUI:            next_state = S_LUI;
                        OP_AUIPC:          next_state = S_ALUWB;
                        default:           next_state = S_ILLEGAL;
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a  = SRC_A_RS1;
                    alu_src_b  = SRC_B_IMM;
                    next_state = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
                end
                S_MEMREAD: begin
                    mem_req  = 1'b1;
                    addr_src = 1'b1;
                    if (mem_ready) next_state = S_MEMWB;
                end
                S_MEMWB: begin
                    result_src = RES_MEMDATA;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                    next_state = S_FETCH;
                end
                S_MEMWRITE: begin
                    mem_req  = 1'b1;
                    mem_we   = 1'b1;
                    addr_src = 1'b1;
                    if (mem_ready) begin
                        instr_done = 1'b1;
                        next_state = S_FETCH;
                    end
                end
                S_EXECR: begin
                    alu_src_a  = SRC_A_RS1;
                    alu_src_b  = SRC_B_RS2;
                    alu_op     = dec_op;
                    next_state = S_ALUWB;
                end
                S_EXECI: begin
                    alu_src_a  = SRC_A_RS1;
                    alu_src_b  = SRC_B_IMM;
                    alu_op     = dec_op;
                    next_state = S_ALUWB;
                end
                S_ALUWB: begin
                    result_src = RES_ALUOUT;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                    next_state = S_FETCH;
                end
                S_BRANCH: begin
                    // Comparison result arrives on the ALU flags; target sits in ALUOut
                    alu_src_a = SRC_A_RS1;
                    alu_src_b = SRC_B_RS2;
                    pc_src    = 1'b1;
                    case (funct3[2:1])
                        2'b00: begin
                            alu_op = ALU_SUB;
                            take   = alu_zero ^ funct3[0];
                        end
                        2'b10: begin
                            alu_op = ALU_SLT;
                            take   = alu_lsb ^ funct3[0];
                        end
                        2'b11: begin
                            alu_op = ALU_SLTU;
                            take   = alu_lsb ^ funct3[0];
                        end
                        default: take = 1'b0;
                    endcase
                    if (funct3[2:1] == 2'b01) begin
                        next_state = S_ILLEGAL;
                    end else begin
                        pc_write   = take;
                        instr_done = 1'b1;
                        next_state = S_FETCH;
                    end
                end
                S_JALRADR: begin
                    alu_src_a  = SRC_A_RS1;
                    alu_src_b  = SRC_B_IMM;
                    next_state = S_JAL;
                end
                S_JAL: begin
                    // Jump to ALUOut while computing the link address oldPC+4
                    pc_write   = 1'b1;
                    pc_src     = 1'b1;
                    alu_src_a  = SRC_A_OLDPC;
                    alu_src_b  = SRC_B_FOUR;
                    next_state = S_ALUWB;
                end
                S_LUI: begin
                    alu_src_b  = SRC_B_IMM;
                    alu_op     = ALU_LUI;
                    next_state = S_ALUWB;
                end
                S_ILLEGAL: begin
                    illegal    = 1'b1;
                    next_state = S_ILLEGAL;
                end
                default: next_state = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. Each instruction is turned
// into a per-cycle plan (inputs plus the outputs they must produce) from the
// instruction-class timing rules; a compare process checks every cycle.
module tb_multicycle_controller;
    import multicycle_controller_pkg::*;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       alu_zero;
    logic       alu_lsb;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       addr_src;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    alu_ops_t   alu_op;
    logic [1:0] result_src;
    logic       reg_write;
    logic       instr_done;
    logic       illegal;

    multicycle_controller dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .alu_zero   (alu_zero),
        .alu_lsb    (alu_lsb),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .addr_src   (addr_src),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .result_src (result_src),
        .reg_write  (reg_write),
        .instr_done (instr_done),
        .illegal    (illegal)
    );

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       addr_src;
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [3:0] op;
        logic [1:0] result_src;
        logic       reg_write;
        logic       instr_done;
        logic       illegal;
    } outs_t;

    typedef struct {
        logic       rst;
        logic       ready;
        logic       zero;
        logic       lsb;
        logic [6:0] opc;
        logic [2:0] f3;
        logic       f7;
        logic       first;
        outs_t      exp;
    } cyc_t;

    cyc_t        plan_q[$];
    logic [19:0] exp_q[$];

    int checks = 0;
    int passes = 0;
    int cyc_cnt = 0;
    int last_len = 0;

    logic [6:0] cur_opc;
    logic [2:0] cur_f3;
    logic       cur_f7;
    bit         br_fix = 0;
    logic       br_z = 0;
    logic       br_l = 0;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic outs_t dflt();
        outs_t o;
        o = '0;
        o.op = ALU_ADD;
        return o;
    endfunction

    // ALU operation table from funct3 / funct7b5
    function automatic logic [3:0] model_op(input bit is_r, input logic [2:0] f3, input logic f7);
        case (f3)
            3'd0: return (is_r && f7) ? ALU_SUB : ALU_ADD;
            3'd1: return ALU_SLL;
            3'd2: return ALU_SLT;
            3'd3: return ALU_SLTU;
            3'd4: return ALU_XOR;
            3'd5: return f7 ? ALU_SRA : ALU_SRL;
            3'd6: return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic bit is_legal(input logic [6:0] o);
        return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
               o == 7'b0010011 || o == 7'b1100011 || o == 7'b1101111 ||
               o == 7'b1100111 || o == 7'b0110111 || o == 7'b0010111;
    endfunction

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) $display("FAIL %s: got %0h expected %0h", name, act, req);
        else passes++;
    endfunction

    // driver tasks: build the plan
    task automatic push_cyc(input outs_t e, input logic r, input logic rdy,
                            input logic z, input logic l, input logic first);
        cyc_t c;
        c.rst = r; c.ready = rdy; c.zero = z; c.lsb = l;
        c.opc = cur_opc; c.f3 = cur_f3; c.f7 = cur_f7;
        c.first = first; c.exp = e;
        plan_q.push_back(c);
    endtask

    task automatic push_plain(input outs_t e, input logic first);
        push_cyc(e, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), first);
    endtask

    task automatic plan_rst(input int n);
        for (int i = 0; i < n; i++)
            push_cyc(dflt(), 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
    endtask

    // a memory phase: w wait cycles then the completing cycle (e_done)
    task automatic plan_mem(input outs_t e_wait, input outs_t e_done, input int w, input logic first);
        for (int i = 0; i < w; i++)
            push_cyc(e_wait, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), first && i == 0);
        push_cyc(e_done, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), first && w == 0);
    endtask

    task automatic plan_illegal(input int n);
        outs_t e;
        e = dflt(); e.illegal = 1'b1;
        for (int i = 0; i < n; i++) push_plain(e, 1'b0);
        plan_rst(1);
    endtask

    task automatic plan_wb(input logic [1:0] rs);
        outs_t e;
        e = dflt(); e.result_src = rs; e.reg_write = 1'b1; e.instr_done = 1'b1;
        push_plain(e, 1'b0);
    endtask

    // whole instruction: fetch, decode, class-specific tail; abort_w >= 0 resets a store mid-wait
    task automatic plan_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                              input int wf, input int wm, input int abort_w);
        outs_t e, e2;
        bit take;
        logic z, l;
        cur_opc = o; cur_f3 = f3; cur_f7 = f7;
        e = dflt(); e.mem_req = 1'b1;
        e2 = e; e2.ir_write = 1'b1; e2.pc_write = 1'b1; e2.src_b = 2'd2;
        plan_mem(e, e2, wf, 1'b1);
        e = dflt(); e.src_a = 2'd1; e.src_b = 2'd1;
        push_plain(e, 1'b0);
        case (o)
            7'b0000011, 7'b0100011: begin
                e = dflt(); e.src_a = 2'd2; e.src_b = 2'd1;
                push_plain(e, 1'b0);
                e = dflt(); e.mem_req = 1'b1; e.addr_src = 1'b1; e.mem_we = (o == 7'b0100011);
                e2 = e; e2.instr_done = (o == 7'b0100011);
                if (abort_w >= 0) begin
                    for (int i = 0; i < abort_w; i++)
                        push_cyc(e, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                    plan_rst(1);
                end else begin
                    plan_mem(e, e2, wm, 1'b0);
                    if (o == 7'b0000011) plan_wb(2'd1);
                end
            end
            7'b0110011, 7'b0010011: begin
                e = dflt(); e.src_a = 2'd2; e.src_b = (o == 7'b0110011) ? 2'd0 : 2'd1;
                e.op = model_op(o == 7'b0110011, f3, f7);
                push_plain(e, 1'b0);
                plan_wb(2'd0);
            end
            7'b1100011: begin
                z = br_fix ? br_z : 1'($urandom_range(0, 1));
                l = br_fix ? br_l : 1'($urandom_range(0, 1));
                e = dflt(); e.src_a = 2'd2; e.src_b = 2'd0; e.pc_src = 1'b1;
                if (f3 == 3'd2 || f3 == 3'd3) begin
                    push_cyc(e, 1'b0, 1'b0, z, l, 1'b0);
                    plan_illegal($urandom_range(1, 3));
                end else begin
                    if (f3 < 3'd2) begin
                        e.op = ALU_SUB;
                        take = (f3 == 3'd0) ? z : !z;
                    end else begin
                        e.op = (f3 >= 3'd6) ? ALU_SLTU : ALU_SLT;
                        take = f3[0] ? !l : l;
                    end
                    e.pc_write = take; e.instr_done = 1'b1;
                    push_cyc(e, 1'b0, 1'($urandom_range(0, 1)), z, l, 1'b0);
                end
            end
            7'b1101111, 7'b1100111: begin
                if (o == 7'b1100111) begin
                    e = dflt(); e.src_a = 2'd2; e.src_b = 2'd1;
                    push_plain(e, 1'b0);
                end
                e = dflt(); e.pc_write = 1'b1; e.pc_src = 1'b1; e.src_a = 2'd1; e.src_b = 2'd2;
                push_plain(e, 1'b0);
                plan_wb(2'd0);
            end
            7'b0110111: begin
                e = dflt(); e.src_b = 2'd1; e.op = ALU_LUI;
                push_plain(e, 1'b0);
                plan_wb(2'd0);
            end
            7'b0010111: plan_wb(2'd0);
            default: plan_illegal($urandom_range(1, 4));
        endcase
    endtask

    // drive the plan one cycle per falling edge, queueing expectations
    task automatic run_plan();
        cyc_t c;
        while (plan_q.size() > 0) begin
            c = plan_q.pop_front();
            @(negedge clk);
            rst = c.rst; mem_ready = c.ready; alu_zero = c.zero; alu_lsb = c.lsb;
            opcode = c.opc; funct3 = c.f3; funct7b5 = c.f7;
            exp_q.push_back({c.first, c.exp});
        end
        @(negedge clk);
        rst = 1'b0;
        #5;
    endtask

    // scoreboard: compare every planned cycle, and time instruction latency
    always begin
        logic [19:0] ent;
        outs_t a;
        @(negedge clk);
        #3;
        if (exp_q.size() > 0) begin
            ent = exp_q.pop_front();
            a.mem_req = mem_req; a.mem_we = mem_we; a.addr_src = addr_src;
            a.ir_write = ir_write; a.pc_write = pc_write; a.pc_src = pc_src;
            a.src_a = alu_src_a; a.src_b = alu_src_b; a.op = alu_op;
            a.result_src = result_src; a.reg_write = reg_write;
            a.instr_done = instr_done; a.illegal = illegal;
            checks++;
            if (a !== ent[18:0])
                $display("FAIL cycle_outputs t=%0t opc=%b f3=%0d: got %05h expected %05h",
                         $time, opcode, funct3, a, ent[18:0]);
            else
                passes++;
            cyc_cnt = ent[19] ? 1 : cyc_cnt + 1;
            if (a.instr_done) last_len = cyc_cnt;
        end
    end

    task automatic directed(input string name, input logic [6:0] o, input logic [2:0] f3,
                            input logic f7, input int wm, input int req_len);
        plan_instr(o, f3, f7, 0, wm, -1);
        check({name, "_plan_len"}, 32'(plan_q.size()), 32'(req_len));
        last_len = 0;
        run_plan();
        check({name, "_latency"}, 32'(last_len), 32'(req_len));
    endtask

    initial begin
        logic [31:0] word;
        logic [6:0]  o;
        int          k;
        rst = 1'b1; mem_ready = 1'b0; alu_zero = 1'b0; alu_lsb = 1'b0;
        opcode = '0; funct3 = '0; funct7b5 = 1'b0;
        cur_opc = '0; cur_f3 = '0; cur_f7 = 1'b0;

        plan_rst(3);
        run_plan();

        // add x3,x1,x2
        word = 32'h002081B3;
        directed("add", word[6:0], word[14:12], word[30], 0, 4);
        check("model_sub", 32'(model_op(1, 3'd0, 1'b1)), 32'(ALU_SUB));
        check("model_srai", 32'(model_op(0, 3'd5, 1'b1)), 32'(ALU_SRA));
        check("model_addi_f7", 32'(model_op(0, 3'd0, 1'b1)), 32'(ALU_ADD));
        directed("sub", 7'b0110011, 3'd0, 1'b1, 0, 4);
        directed("srai", 7'b0010011, 3'd5, 1'b1, 0, 4);
        directed("addi", 7'b0010011, 3'd0, 1'b1, 0, 4);
        directed("lw_wait3", 7'b0000011, 3'd2, 1'b0, 3, 8);
        directed("sw", 7'b0100011, 3'd2, 1'b0, 0, 4);
        directed("lui", 7'b0110111, 3'd0, 1'b0, 0, 4);
        directed("auipc", 7'b0010111, 3'd0, 1'b0, 0, 3);
        directed("jal", 7'b1101111, 3'd0, 1'b0, 0, 4);
        directed("jalr", 7'b1100111, 3'd0, 1'b0, 0, 5);

        br_fix = 1; br_z = 1'b1; br_l = 1'b0;
        plan_instr(7'b1100011, 3'd0, 1'b0, 0, 0, -1);
        check("beq_taken_plan", {31'd0, plan_q[2].exp.pc_write}, 32'd1);
        run_plan();
        br_z = 1'b0;
        plan_instr(7'b1100011, 3'd0, 1'b0, 0, 0, -1);
        check("beq_not_taken_plan", {31'd0, plan_q[2].exp.pc_write}, 32'd0);
        run_plan();
        br_z = 1'b0; br_l = 1'b1;
        directed("bltu", 7'b1100011, 3'd6, 1'b0, 0, 3);
        br_fix = 0;

        // illegal opcode held for 10 cycles, then reset back to fetch
        cur_opc = 7'b0000000; cur_f3 = '0; cur_f7 = 1'b0;
        plan_instr(7'b0000000, 3'd0, 1'b0, 0, 0, -1);
        while (plan_q.size() > 0) void'(plan_q.pop_back());
        plan_instr(7'b0000000, 3'd0, 1'b0, 0, 0, 0);
        while (plan_q.size() > 2) void'(plan_q.pop_back());
        plan_illegal(10);
        run_plan();

        // reset while a store waits for memory
        plan_instr(7'b0100011, 3'd2, 1'b0, 1, 0, 2);
        run_plan();
        directed("add_after_abort", 7'b0110011, 3'd0, 1'b0, 0, 4);

        // randomized instruction stream
        for (int n = 0; n < 200; n++) begin
            k = $urandom_range(0, 10);
            case (k)
                0: o = 7'b0110011;
                1: o = 7'b0010011;
                2: o = 7'b0000011;
                3: o = 7'b0100011;
                4: o = 7'b1100011;
                5: o = 7'b1101111;
                6: o = 7'b1100111;
                7: o = 7'b0110111;
                8: o = 7'b0010111;
                9: begin
                    o = 7'($urandom_range(0, 127));
                    while (is_legal(o)) o = 7'($urandom_range(0, 127));
                end
                default: o = 7'b0100011;
            endcase
            plan_instr(o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                       $urandom_range(0, 2), $urandom_range(0, 3),
                       (k == 10) ? $urandom_range(0, 3) : -1);
            run_plan();
        end

        #20;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
